cam_array: RTL and testbench
============================

// Module: cam_array
// PURPOSE
//  Parametrised content-addressable memory: DEPTH entries of WIDTH bits, each with a valid bit.
//  Supports indexed write, read, invalidate and flush, plus an associative search.
//  Search returns hit, lowest matching index and multi-hit flag.
//  Successor to the fixed 32x32 CAM; sits beside the lookup/tag logic as a registered lookup table.
// PARAMETERS
//  WIDTH       32                 entry data width in bits
//  DEPTH       32                 number of entries; any value >= 2
//  ADDR_WIDTH  $clog2(DEPTH)      index width; derived, never overridden
// PORTS
//  clk_i               in   1           clock; all state on rising edge
//  rst_ni              in   1           reset, asynchronous assert, active-low
//  flush_i             in   1           clear every valid bit
//  write_enable_i      in   1           write write_data_i to write_index_i, set valid
//  write_index_i       in   ADDR_WIDTH  write target
//  write_data_i        in   WIDTH       write data
//  inval_enable_i      in   1           clear valid of inval_index_i
//  inval_index_i       in   ADDR_WIDTH  invalidate target
//  read_enable_i       in   1           indexed read request
//  read_index_i        in   ADDR_WIDTH  read target
//  search_enable_i     in   1           associative search request
//  search_data_i       in   WIDTH       search key
//  search_mask_i       in   WIDTH       compare-enable bit mask (only with CAM_SEARCH_MASK_EN)
//  read_valid_o        out  1           read result valid: read performed AND entry valid
//  read_value_o        out  WIDTH       read data; 0 when read_valid_o=0
//  search_valid_o      out  1           search result present (pulse, 1 cycle)
//  search_hit_o        out  1           at least one valid entry matched
//  search_index_o      out  ADDR_WIDTH  lowest matching index; 0 on miss
//  search_multi_o      out  1           two or more valid entries matched
// BEHAVIOUR
//  - Reset (rst_ni=0): all valid bits 0, all outputs 0. Data storage is not reset.
//  - Read and search both have latency 1: request at edge N, registered result visible after edge N+1.
//  - Each _valid_o is a one-cycle pulse per request; back-to-back requests give back-to-back results.
//  - A read or search sees array state BEFORE any same-cycle write/inval/flush (read-before-write).
//  - Match rule: entry valid AND (entry data == search_data_i).
//  - Priority encoder selects the lowest matching index; search_multi_o set when popcount(match) >= 2.
//  - Update priority within one cycle:
//      1. flush_i: all valid bits cleared; same-cycle write and inval are dropped.
//      2. write_enable_i: sets the entry; if inval targets the same index, the write wins.
//      3. inval_enable_i: applied when it targets a different index from the write.
//  - Index >= DEPTH (non-power-of-two DEPTH):
//      - write/inval: ignored.
//      - read: read_valid_o=0, read_value_o=0.
//  - Rewriting identical data to two indices is legal; search then reports lowest index with multi=1.
//  - Reset asserted mid-operation: pending results are lost; outputs return to 0 asynchronously.
// CONFIGURATION
//  CAM_SEARCH_MASK_EN defined:
//    - search_mask_i port present.
//    - Match = valid AND ((entry ^ key) & mask)==0.
//    - A mask of all zeros matches every valid entry.
//  CAM_SEARCH_MASK_EN undefined:
//    - Port absent; exact match over all WIDTH bits.
// STRUCTURE
//  - Package cam_pkg: typedefs for entry data and index, plus the function lowest_index(match vector).
//  - Sub-module cam_row, instantiated DEPTH times via generate:
//      - holds data reg + valid bit;
//      - takes write/inval decode and key (+mask);
//      - outputs match bit and stored data.
//  - Top level: decode, read mux, priority encoder, popcount>=2, output registers.
// TESTING
//  1. Reset, then read idx 3 and search 0xDEADBEEF -> read_valid_o=0, search_valid_o=1, search_hit_o=0, index 0.
//  2. Write 0xA5A5A5A5 @5 and @9, then search 0xA5A5A5A5 -> hit=1, index=5, multi=1.
//     Then inval 5, search again -> hit=1, index=9, multi=0.
//  3. Same cycle: write 0x11 @2 + search 0x11 -> miss.
//     Next-cycle search 0x11 -> hit, index 2.
//     Read @2 -> read_valid_o=1, read_value_o=0x11.
//  4. Same cycle: write 0x22 @7 + inval 7 -> entry 7 valid with 0x22.
//     Same cycle: flush + write 0x33 @1 -> all entries invalid; search 0x33 misses.
//  5. DEPTH=20: write @25 then read @25 -> write ignored, read_valid_o=0.
//     Search key never written -> miss.
//  6. With CAM_SEARCH_MASK_EN: entries 0x12345678@0, 0x12340000@4;
//     key 0x1234FFFF, mask 0xFFFF0000 -> index 0, multi=1.
//     Mask 0 with no valid entries -> miss.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and helpers for the cam_array content-addressable memory.
// The data/index typedefs describe the default 32x32 configuration; the
// wide match/index types let one priority encoder serve any DEPTH up to
// CAM_MAX_DEPTH. Optional feature macro used by this slice: CAM_SEARCH_MASK_EN.
package cam_pkg;

  localparam int CAM_DEFAULT_WIDTH   = 32;
  localparam int CAM_DEFAULT_DEPTH   = 32;
  localparam int CAM_MAX_DEPTH       = 256;
  localparam int CAM_MAX_INDEX_WIDTH = $clog2(CAM_MAX_DEPTH);

  typedef logic [CAM_DEFAULT_WIDTH-1:0]          cam_data_t;
  typedef logic [$clog2(CAM_DEFAULT_DEPTH)-1:0]  cam_index_t;
  typedef logic [CAM_MAX_DEPTH-1:0]              cam_match_t;
  typedef logic [CAM_MAX_INDEX_WIDTH-1:0]        cam_wide_index_t;

  // Position of the lowest set bit of a match vector; 0 when nothing matched.
  // Scanning from the top down lets the lowest hit overwrite any higher one.
  function automatic cam_wide_index_t lowest_index(input cam_match_t match);
    cam_wide_index_t idx;
    idx = '0;
    for (int i = CAM_MAX_DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx = cam_wide_index_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cam_row.sv
// One CAM entry: stored data, its valid bit and the per-entry comparator.
// With CAM_SEARCH_MASK_EN defined a compare-enable mask is applied to the key.
module cam_row
  import cam_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             inval_en,
  input  logic [WIDTH-1:0] key,
`ifdef CAM_SEARCH_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic             match,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Valid bit: flush beats write, and write beats an invalidate of this entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (write_en) begin
      valid <= 1'b1;
    end else if (inval_en) begin
      valid <= 1'b0;
    end
  end

  // Data storage is deliberately left out of reset; valid guards its use.
  always_ff @(posedge clk) begin
    if (write_en && !flush) begin
      data <= write_data;
    end
  end

`ifdef CAM_SEARCH_MASK_EN
  assign match = valid && (((data ^ key) & mask) == '0);
`else
  assign match = valid && (data == key);
`endif

endmodule

// File: rtl/cam_array.sv
// Parametrised CAM: DEPTH entries of WIDTH bits with indexed write, read,
// invalidate, flush and an associative search reporting hit, lowest index
// and multi-hit. Read and search results are registered (latency 1) and
// observe the array as it was before same-cycle updates.
// Optional feature macro: CAM_SEARCH_MASK_EN adds search_mask_i.
module cam_array
  import cam_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  write_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic                  inval_enable_i,
  input  logic [ADDR_WIDTH-1:0] inval_index_i,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic                  search_enable_i,
  input  logic [WIDTH-1:0]      search_data_i,
`ifdef CAM_SEARCH_MASK_EN
  input  logic [WIDTH-1:0]      search_mask_i,
`endif
  output logic                  read_valid_o,
  output logic [WIDTH-1:0]      read_value_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic [ADDR_WIDTH-1:0] search_index_o,
  output logic                  search_multi_o
);

  logic [DEPTH-1:0] row_write;
  logic [DEPTH-1:0] row_inval;
  logic [DEPTH-1:0] row_match;
  logic [DEPTH-1:0] row_valid;
  logic [WIDTH-1:0] row_data [DEPTH];

  logic                  read_hit;
  logic [WIDTH-1:0]      read_data;
  cam_match_t            match_wide;
  logic [ADDR_WIDTH-1:0] search_lowest;
  logic                  search_multi;

  // Equality decode means an index >= DEPTH selects no row and is dropped.
  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    localparam logic [ADDR_WIDTH-1:0] ROW_INDEX = ADDR_WIDTH'(g);

    assign row_write[g] = write_enable_i && (write_index_i == ROW_INDEX);
    assign row_inval[g] = inval_enable_i && (inval_index_i == ROW_INDEX);

    cam_row #(.WIDTH(WIDTH)) u_row (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .flush      (flush_i),
      .write_en   (row_write[g]),
      .write_data (write_data_i),
      .inval_en   (row_inval[g]),
      .key        (search_data_i),
`ifdef CAM_SEARCH_MASK_EN
      .mask       (search_mask_i),
`endif
      .match      (row_match[g]),
      .data       (row_data[g]),
      .valid      (row_valid[g])
    );
  end

  // Read mux; an out-of-range index matches no row and reads as invalid zero.
  always_comb begin
    read_hit  = 1'b0;
    read_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (read_index_i == ADDR_WIDTH'(i)) begin
        read_hit  = row_valid[i];
        read_data = row_data[i];
      end
    end
  end

  // Widen the match vector so the shared package encoder can be used.
  always_comb begin
    match_wide             = '0;
    match_wide[DEPTH-1:0]  = row_match;
  end

  assign search_lowest = ADDR_WIDTH'(lowest_index(match_wide));
  // Clearing the lowest set bit leaves something only if two or more matched.
  assign search_multi  = |(row_match & (row_match - DEPTH'(1)));

  // Result registers: one-cycle pulses per request, zero when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_valid_o   <= 1'b0;
      read_value_o   <= '0;
      search_valid_o <= 1'b0;
      search_hit_o   <= 1'b0;
      search_index_o <= '0;
      search_multi_o <= 1'b0;
    end else begin
      read_valid_o   <= read_enable_i && read_hit;
      read_value_o   <= (read_enable_i && read_hit) ? read_data : '0;
      search_valid_o <= search_enable_i;
      search_hit_o   <= search_enable_i && (|row_match);
      search_index_o <= (search_enable_i && (|row_match)) ? search_lowest : '0;
      search_multi_o <= search_enable_i && search_multi;
    end
  end

endmodule

// File: tb/tb_cam_array.sv
// Scoreboard bench for cam_array: a 32-entry instance for the main behaviour
// and a 20-entry instance for out-of-range indices. Expected results are queued
// with the cycle they are due; monitors pop and compare on the falling edge.
// Masked-search vectors run only when CAM_SEARCH_MASK_EN is defined.
module tb_cam_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 32-entry instance signals
  logic        flush, write_enable, inval_enable, read_enable, search_enable;
  logic [4:0]  write_index, inval_index, read_index;
  logic [31:0] write_data, search_data;
`ifdef CAM_SEARCH_MASK_EN
  logic [31:0] search_mask;
`endif
  logic        read_valid, search_valid, search_hit, search_multi;
  logic [31:0] read_value;
  logic [4:0]  search_index;

  // 20-entry instance signals
  logic        d20_flush, d20_write_enable, d20_inval_enable, d20_read_enable, d20_search_enable;
  logic [4:0]  d20_write_index, d20_inval_index, d20_read_index;
  logic [31:0] d20_write_data, d20_search_data;
`ifdef CAM_SEARCH_MASK_EN
  logic [31:0] d20_search_mask;
`endif
  logic        d20_read_valid, d20_search_valid, d20_search_hit, d20_search_multi;
  logic [31:0] d20_read_value;
  logic [4:0]  d20_search_index;

  cam_array #(.WIDTH(32), .DEPTH(32)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .write_enable_i  (write_enable),
    .write_index_i   (write_index),
    .write_data_i    (write_data),
    .inval_enable_i  (inval_enable),
    .inval_index_i   (inval_index),
    .read_enable_i   (read_enable),
    .read_index_i    (read_index),
    .search_enable_i (search_enable),
    .search_data_i   (search_data),
`ifdef CAM_SEARCH_MASK_EN
    .search_mask_i   (search_mask),
`endif
    .read_valid_o    (read_valid),
    .read_value_o    (read_value),
    .search_valid_o  (search_valid),
    .search_hit_o    (search_hit),
    .search_index_o  (search_index),
    .search_multi_o  (search_multi)
  );

  cam_array #(.WIDTH(32), .DEPTH(20)) dut20 (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (d20_flush),
    .write_enable_i  (d20_write_enable),
    .write_index_i   (d20_write_index),
    .write_data_i    (d20_write_data),
    .inval_enable_i  (d20_inval_enable),
    .inval_index_i   (d20_inval_index),
    .read_enable_i   (d20_read_enable),
    .read_index_i    (d20_read_index),
    .search_enable_i (d20_search_enable),
    .search_data_i   (d20_search_data),
`ifdef CAM_SEARCH_MASK_EN
    .search_mask_i   (d20_search_mask),
`endif
    .read_valid_o    (d20_read_valid),
    .read_value_o    (d20_read_value),
    .search_valid_o  (d20_search_valid),
    .search_hit_o    (d20_search_hit),
    .search_index_o  (d20_search_index),
    .search_multi_o  (d20_search_multi)
  );

  typedef struct {
    int          due;
    logic        valid;
    logic [31:0] value;
    logic        hit;
    logic [4:0]  idx;
    logic        multi;
  } exp_t;

  exp_t rd_q[$];
  exp_t sr_q[$];
  exp_t rd20_q[$];
  exp_t sr20_q[$];

  // Single comparison point: every check steps the counters here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expRead(input logic v, input logic [31:0] val);
    exp_t e;
    e.due = cyc + 1; e.valid = v; e.value = val; e.hit = 1'b0; e.idx = '0; e.multi = 1'b0;
    rd_q.push_back(e);
  endtask

  task automatic expSearch(input logic h, input logic [4:0] i, input logic m);
    exp_t e;
    e.due = cyc + 1; e.valid = 1'b1; e.value = '0; e.hit = h; e.idx = i; e.multi = m;
    sr_q.push_back(e);
  endtask

  task automatic expRead20(input logic v, input logic [31:0] val);
    exp_t e;
    e.due = cyc + 1; e.valid = v; e.value = val; e.hit = 1'b0; e.idx = '0; e.multi = 1'b0;
    rd20_q.push_back(e);
  endtask

  task automatic expSearch20(input logic h, input logic [4:0] i, input logic m);
    exp_t e;
    e.due = cyc + 1; e.valid = 1'b1; e.value = '0; e.hit = h; e.idx = i; e.multi = m;
    sr20_q.push_back(e);
  endtask

  // Drive one cycle of 32-entry controls on the falling edge.
  task automatic applyStimulus(input logic fl, input logic we, input logic [4:0] wi, input logic [31:0] wd,
                               input logic ie, input logic [4:0] ii, input logic re, input logic [4:0] ri,
                               input logic se, input logic [31:0] sd, input logic [31:0] sm);
    @(negedge clk);
    flush = fl; write_enable = we; write_index = wi; write_data = wd;
    inval_enable = ie; inval_index = ii; read_enable = re; read_index = ri;
    search_enable = se; search_data = sd;
`ifdef CAM_SEARCH_MASK_EN
    search_mask = sm;
`endif
  endtask

  task automatic applyStimulus20(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                                 input logic re, input logic [4:0] ri, input logic se, input logic [31:0] sd);
    @(negedge clk);
    d20_write_enable = we; d20_write_index = wi; d20_write_data = wd;
    d20_read_enable = re; d20_read_index = ri; d20_search_enable = se; d20_search_data = sd;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '1);
  endtask

  task automatic doWrite(input logic [4:0] i, input logic [31:0] d);
    applyStimulus(0, 1, i, d, 0, 0, 0, 0, 0, 0, '1);
  endtask

  task automatic doInval(input logic [4:0] i);
    applyStimulus(0, 0, 0, 0, 1, i, 0, 0, 0, 0, '1);
  endtask

  task automatic doRead(input logic [4:0] i, input logic v, input logic [31:0] val);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, i, 0, 0, '1);
    expRead(v, val);
  endtask

  task automatic doSearch(input logic [31:0] k, input logic h, input logic [4:0] i, input logic m);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, k, '1);
    expSearch(h, i, m);
  endtask

  // Monitor for the 32-entry instance.
  exp_t mon_rd, mon_sr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        mon_rd = rd_q.pop_front();
        checkOutput("read_valid", 32'(read_valid), 32'(mon_rd.valid));
        checkOutput("read_value", read_value, mon_rd.value);
      end else begin
        checkOutput("read_idle", 32'(read_valid), 32'd0);
      end
      if (sr_q.size() > 0 && sr_q[0].due == cyc) begin
        mon_sr = sr_q.pop_front();
        checkOutput("search_valid", 32'(search_valid), 32'd1);
        checkOutput("search_hit", 32'(search_hit), 32'(mon_sr.hit));
        checkOutput("search_index", 32'(search_index), 32'(mon_sr.idx));
        checkOutput("search_multi", 32'(search_multi), 32'(mon_sr.multi));
      end else begin
        checkOutput("search_idle", 32'(search_valid), 32'd0);
      end
    end
  end

  // Monitor for the 20-entry instance.
  exp_t mon_rd20, mon_sr20;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd20_q.size() > 0 && rd20_q[0].due == cyc) begin
        mon_rd20 = rd20_q.pop_front();
        checkOutput("d20_read_valid", 32'(d20_read_valid), 32'(mon_rd20.valid));
        checkOutput("d20_read_value", d20_read_value, mon_rd20.value);
      end else begin
        checkOutput("d20_read_idle", 32'(d20_read_valid), 32'd0);
      end
      if (sr20_q.size() > 0 && sr20_q[0].due == cyc) begin
        mon_sr20 = sr20_q.pop_front();
        checkOutput("d20_search_valid", 32'(d20_search_valid), 32'd1);
        checkOutput("d20_search_hit", 32'(d20_search_hit), 32'(mon_sr20.hit));
        checkOutput("d20_search_index", 32'(d20_search_index), 32'(mon_sr20.idx));
        checkOutput("d20_search_multi", 32'(d20_search_multi), 32'(mon_sr20.multi));
      end else begin
        checkOutput("d20_search_idle", 32'(d20_search_valid), 32'd0);
      end
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    flush = 0; write_enable = 0; write_index = 0; write_data = 0;
    inval_enable = 0; inval_index = 0; read_enable = 0; read_index = 0;
    search_enable = 0; search_data = 0;
`ifdef CAM_SEARCH_MASK_EN
    search_mask = '1;
    d20_search_mask = '1;
`endif
    d20_flush = 0; d20_write_enable = 0; d20_write_index = 0; d20_write_data = 0;
    d20_inval_enable = 0; d20_inval_index = 0; d20_read_enable = 0; d20_read_index = 0;
    d20_search_enable = 0; d20_search_data = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_read_valid", 32'(read_valid), 32'd0);
    checkOutput("rst_read_value", read_value, 32'd0);
    checkOutput("rst_search_valid", 32'(search_valid), 32'd0);
    checkOutput("rst_search_hit", 32'(search_hit), 32'd0);
    checkOutput("rst_search_index", 32'(search_index), 32'd0);
    checkOutput("rst_d20_read_valid", 32'(d20_read_valid), 32'd0);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Empty array: read and search in the same cycle
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 1, 32'hDEADBEEF, '1);
    expRead(0, 32'h0);
    expSearch(0, 0, 0);

    // Duplicate data, multi-hit, then invalidate the lower copy
    doWrite(5, 32'hA5A5A5A5);
    doWrite(9, 32'hA5A5A5A5);
    doSearch(32'hA5A5A5A5, 1, 5, 1);
    doInval(5);
    doSearch(32'hA5A5A5A5, 1, 9, 0);

    // Search sees state before a same-cycle write
    applyStimulus(0, 1, 2, 32'h11, 0, 0, 0, 0, 1, 32'h11, '1);
    expSearch(0, 0, 0);
    doSearch(32'h11, 1, 2, 0);
    doRead(2, 1, 32'h11);

    // Write and invalidate of the same index: write wins
    applyStimulus(0, 1, 7, 32'h22, 1, 7, 0, 0, 0, 0, '1);
    doRead(7, 1, 32'h22);
    doSearch(32'h22, 1, 7, 0);

    // Write and invalidate of different indices: both apply
    applyStimulus(0, 1, 6, 32'h66, 1, 2, 0, 0, 0, 0, '1);
    doRead(2, 0, 32'h0);
    doSearch(32'h66, 1, 6, 0);

    // Top and bottom indices, back-to-back reads
    doWrite(31, 32'h77);
    doSearch(32'h77, 1, 31, 0);
    doWrite(0, 32'h77);
    doSearch(32'h77, 1, 0, 1);
    doRead(31, 1, 32'h77);
    doRead(0, 1, 32'h77);

    // Overwrite a valid entry
    doWrite(9, 32'hBB);
    doSearch(32'hA5A5A5A5, 0, 0, 0);
    doRead(9, 1, 32'hBB);

    // Flush drops a same-cycle write
    applyStimulus(1, 1, 1, 32'h33, 0, 0, 0, 0, 0, 0, '1);
    doSearch(32'h33, 0, 0, 0);
    doSearch(32'h22, 0, 0, 0);
    doRead(7, 0, 32'h0);

`ifdef CAM_SEARCH_MASK_EN
    // Masked search
    doWrite(0, 32'h12345678);
    doWrite(4, 32'h12340000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234FFFF, 32'hFFFF0000);
    expSearch(1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12340000, 32'hFFFFFFFF);
    expSearch(1, 4, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    expSearch(1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    expSearch(0, 0, 0);
`endif

    // Reset in the middle of operation
    doWrite(3, 32'hBB);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, '1);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_read_valid", 32'(read_valid), 32'd1);
    checkOutput("pre_reset_read_value", read_value, 32'hBB);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_read_valid", 32'(read_valid), 32'd0);
    checkOutput("async_reset_read_value", read_value, 32'd0);
    read_enable = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doSearch(32'hBB, 0, 0, 0);
    doRead(3, 0, 32'h0);
    idle();

    // 20-entry instance: out-of-range index is ignored
    applyStimulus20(1, 25, 32'hCAFE0025, 0, 0, 0, 0);
    applyStimulus20(0, 0, 0, 1, 25, 0, 0);
    expRead20(0, 32'h0);
    applyStimulus20(0, 0, 0, 0, 0, 1, 32'hCAFE0025);
    expSearch20(0, 0, 0);
    applyStimulus20(1, 19, 32'h19, 0, 0, 0, 0);
    applyStimulus20(0, 0, 0, 0, 0, 1, 32'h19);
    expSearch20(1, 19, 0);
    applyStimulus20(0, 0, 0, 1, 19, 0, 0);
    expRead20(1, 32'h19);
    applyStimulus20(0, 0, 0, 0, 0, 1, 32'h5555);
    expSearch20(0, 0, 0);
    applyStimulus20(0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("read_queue_drained", 32'(rd_q.size()), 32'd0);
    checkOutput("search_queue_drained", 32'(sr_q.size()), 32'd0);
    checkOutput("d20_read_queue_drained", 32'(rd20_q.size()), 32'd0);
    checkOutput("d20_search_queue_drained", 32'(sr20_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
